decimal_print: RTL and testbench

//  Serialises one integer into ASCII decimal characters on a byte stream.

---
 rtl/decimal_print_pkg.sv | 22 ++
 rtl/decimal_print_div10_serial.sv | 68 ++++++
 rtl/decimal_print.sv | 159 +++++++++++++++
 tb/tb_decimal_print.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decimal_print_pkg.sv
// Shared types and ASCII constants for the decimal printer and its serial divider.
package decimal_print_pkg;

  typedef enum logic [2:0] {
    ST_READ,
    ST_DIV,
    ST_PUSH,
    ST_SIGN,
    ST_DIGIT,
    ST_TERM
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // log10(2) ~= 77/256, rounded up: worst-case decimal digits for a b-bit magnitude
  function automatic int calc_digits(input int b);
    return (b * 77 + 255) / 256;
  endfunction

endpackage

// File: rtl/decimal_print_div10_serial.sv
// Restoring divide-by-10, one quotient bit per cycle: start loads, bits cycles later done pulses.
// No backpressure; quotient/rem hold after done until the next start.
module div10_serial #(
  parameter int bits = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [bits-1:0] dividend,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] quotient,
  output logic [3:0]      rem
);

  localparam int CW = $clog2(bits + 1);

  logic [bits-1:0] q_q, q_d;
  logic [4:0]      r_q, r_d;
  logic [5:0]      r_sh;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;

  always_comb begin
    q_d    = q_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    r_sh   = {r_q, q_q[bits-1]};
    if (start) begin
      q_d    = dividend;
      r_d    = '0;
      cnt_d  = CW'(bits);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // dividend bits shift out of the top of q while quotient bits enter at the bottom
      if (r_sh >= 6'd10) begin
        r_d = 5'(r_sh - 6'd10);
        q_d = {q_q[bits-2:0], 1'b1};
      end else begin
        r_d = 5'(r_sh);
        q_d = {q_q[bits-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(1));
  assign quotient = q_q;
  assign rem      = r_q[3:0];

endmodule

// File: rtl/decimal_print.sv
// Prints one integer as ASCII decimal ('-', digits MSD-first, terminator); first byte (bits+1)*n+1 cycles after input.
// out1 holds under backpressure; bytes stream every cycle while out1_ack=1; no new input until the last byte leaves.
module decimal_print
  import decimal_print_pkg::*;
#(
  parameter int         bits      = 16,
  parameter bit         signed_in = 1'b1,
  parameter bit         term_en   = 1'b1,
  parameter logic [7:0] term      = ASCII_LF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] in1,
  input  logic            in1_stb,
  output logic            in1_ack,
  output logic [7:0]      out1,
  output logic            out1_stb,
  input  logic            out1_ack
);

  localparam int digits = calc_digits(bits);
  localparam int CNT_W  = $clog2(digits + 1);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic            neg_q, neg_d;
  logic [3:0]      stack_q [digits];
  logic [3:0]      stack_d [digits];
  logic [7:0]      out1_q, out1_d;
  logic            stb_q, stb_d;
  logic            in1_ack_q, in1_ack_d;

  logic            div_start, div_busy, div_done;
  logic [bits-1:0] div_quot;
  logic [3:0]      div_rem;

  logic            in_xfer, out_xfer, neg_in;
  logic [bits-1:0] mag;
  logic [CNT_W-1:0] idx_cur, idx_nxt;
  logic [3:0]      dig_cur, dig_nxt;

  function automatic logic is_emit(input state_t s);
    return (s == ST_SIGN) || (s == ST_DIGIT) || (s == ST_TERM);
  endfunction

  function automatic logic [7:0] char_for(input state_t s, input logic [3:0] d);
    case (s)
      ST_SIGN: return ASCII_MINUS;
      ST_TERM: return term;
      default: return ASCII_ZERO + {4'h0, d};
    endcase
  endfunction

  assign in_xfer  = in1_stb && in1_ack_q;
  assign out_xfer = stb_q && out1_ack;
  assign neg_in   = signed_in && in1[bits-1];
  // most-negative input negates to itself, which is the correct unsigned magnitude
  assign mag      = neg_in ? (bits'(0) - in1) : in1;

  div10_serial #(.bits(bits)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (state_q == ST_READ ? mag : div_quot),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot),
    .rem      (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    neg_d     = neg_q;
    stack_d   = stack_q;
    div_start = 1'b0;
    case (state_q)
      ST_READ: begin
        if (in_xfer) begin
          neg_d     = neg_in;
          count_d   = '0;
          div_start = !div_busy;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (count_q < CNT_W'(digits)) stack_d[count_q] = div_rem;
        count_d = count_q + 1'b1;
        if (div_quot != '0) begin
          div_start = !div_busy;
          state_d   = ST_DIV;
        end else begin
          state_d = neg_q ? ST_SIGN : ST_DIGIT;
        end
      end
      ST_SIGN: begin
        if (out_xfer) state_d = ST_DIGIT;
      end
      ST_DIGIT: begin
        if (out_xfer) begin
          count_d = count_q - 1'b1;
          if (count_q == CNT_W'(1)) state_d = term_en ? ST_TERM : ST_READ;
        end
      end
      ST_TERM: begin
        if (out_xfer) state_d = ST_READ;
      end
      default: state_d = ST_READ;
    endcase
  end

  // Output register: on a transfer, preload the next state's byte so the stream never bubbles.
  always_comb begin
    idx_cur   = count_q - 1'b1;
    idx_nxt   = count_d - 1'b1;
    dig_cur   = (idx_cur < CNT_W'(digits)) ? stack_q[idx_cur] : 4'h0;
    dig_nxt   = (idx_nxt < CNT_W'(digits)) ? stack_q[idx_nxt] : 4'h0;
    stb_d     = stb_q;
    out1_d    = out1_q;
    in1_ack_d = (state_d == ST_READ);
    if (stb_q) begin
      if (out1_ack) begin
        stb_d = is_emit(state_d);
        if (is_emit(state_d)) out1_d = char_for(state_d, dig_nxt);
      end
    end else if (is_emit(state_q)) begin
      stb_d  = 1'b1;
      out1_d = char_for(state_q, dig_cur);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_READ;
      count_q   <= '0;
      neg_q     <= 1'b0;
      stack_q   <= '{default: 4'h0};
      out1_q    <= 8'h00;
      stb_q     <= 1'b0;
      in1_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      stack_q   <= stack_d;
      out1_q    <= out1_d;
      stb_q     <= stb_d;
      in1_ack_q <= in1_ack_d;
    end
  end

  assign in1_ack  = in1_ack_q;
  assign out1     = out1_q;
  assign out1_stb = stb_q;

endmodule

// File: tb/tb_decimal_print.sv
// Directed and random checks of the decimal printer, signed and unsigned builds side by side.
module tb_decimal_print;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in1 = '0;
  logic        in1_stb = 1'b0;
  logic        in1_ack;
  logic [7:0]  out1;
  logic        out1_stb;
  logic        out1_ack = 1'b1;
  logic        in1_stb_u = 1'b0;
  logic        in1_ack_u;
  logic [7:0]  out1_u;
  logic        out1_stb_u;
  logic        out1_ack_u = 1'b1;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  string rx_s = "";
  string rx_u = "";

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decimal_print #(.bits(16), .signed_in(1'b1), .term_en(1'b1), .term(8'h0A)) u_dut (
    .clk(clk), .rst(rst_n), .in1(in1), .in1_stb(in1_stb), .in1_ack(in1_ack),
    .out1(out1), .out1_stb(out1_stb), .out1_ack(out1_ack)
  );

  decimal_print #(.bits(16), .signed_in(1'b0), .term_en(1'b1), .term(8'h0A)) u_dut_u (
    .clk(clk), .rst(rst_n), .in1(in1), .in1_stb(in1_stb_u), .in1_ack(in1_ack_u),
    .out1(out1_u), .out1_stb(out1_stb_u), .out1_ack(out1_ack_u)
  );

  // Inputs change only at posedge+1, so the negedge sees exactly what the next posedge will.
  always @(negedge clk) begin
    if (rst_n && out1_stb && out1_ack) rx_s = $sformatf("%s%c", rx_s, out1);
    if (rst_n && out1_stb_u && out1_ack_u) rx_u = $sformatf("%s%c", rx_u, out1_u);
  end

  function automatic string hexs(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02h ", r, s[i]);
    return r;
  endfunction

  task automatic send(input int which, input logic [15:0] v, output int t_xfer);
    int   n = 0;
    logic ack;
    @(posedge clk); #1;
    in1 = v;
    if (which == 0) in1_stb = 1'b1; else in1_stb_u = 1'b1;
    do begin
      @(negedge clk);
      ack = (which == 0) ? in1_ack : in1_ack_u;
      n++;
    end while (!ack && n < 500);
    if (!ack) begin
      checks++; errors++;
      $display("FAIL send_timeout value=%h in1_ack never rose", v);
    end
    @(posedge clk); #1;
    t_xfer    = cyc;
    in1_stb   = 1'b0;
    in1_stb_u = 1'b0;
  endtask

  task automatic wait_stream(input int which, input int base, input int nbytes,
                             input bit rand_bp, output string got);
    int n = 0;
    int len;
    do begin
      @(posedge clk); #1;
      if (rand_bp) out1_ack = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      len = (which == 0) ? rx_s.len() : rx_u.len();
      n++;
    end while (len - base < nbytes && n < 3000);
    if (len - base < nbytes) begin
      checks++; errors++;
      $display("FAIL stream_timeout got %0d bytes want %0d", len - base, nbytes);
    end
    got = (which == 0) ? rx_s.substr(base, len - 1) : rx_u.substr(base, len - 1);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in1_ack !== 1'b0 || out1_stb !== 1'b0 || out1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b stb=%b out1=%h want 0 0 00", in1_ack, out1_stb, out1);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (in1_ack !== 1'b1 || in1_ack_u !== 1'b1) begin
      errors++;
      $display("FAIL reset_read got in1_ack=%b/%b want 1/1", in1_ack, in1_ack_u);
    end
  endtask

  task automatic test_zero();
    string got;
    int    t, base;
    base = rx_s.len();
    send(0, 16'd0, t);
    wait_stream(0, base, 2, 1'b0, got);
    checks++;
    if (got != "0\n") begin
      errors++;
      $display("FAIL zero_bytes got=%s want=%s", hexs(got), hexs("0\n"));
    end
    @(negedge clk);
    checks++;
    if (in1_ack !== 1'b1) begin
      errors++;
      $display("FAIL zero_ack_return got in1_ack=%b want 1", in1_ack);
    end
  endtask

  task automatic test_latency();
    string got;
    int    t, base, n;
    base = rx_s.len();
    send(0, 16'd12345, t);
    n = 0;
    while (out1_stb !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc - t != 5 * 17 + 1) begin
      errors++;
      $display("FAIL latency_12345 got %0d cycles want %0d", cyc - t, 5 * 17 + 1);
    end
    wait_stream(0, base, 6, 1'b0, got);
    checks++;
    if (got != "12345\n") begin
      errors++;
      $display("FAIL bytes_12345 got=%s want=%s", hexs(got), hexs("12345\n"));
    end
  endtask

  task automatic test_min_neg();
    string got, exp;
    int    t, base;
    logic [15:0] vals [3] = '{16'h8000, 16'hFFFF, 16'h8000};
    int    which [3] = '{0, 1, 1};
    string exps  [3] = '{"-32768\n", "65535\n", "32768\n"};
    for (int i = 0; i < 3; i++) begin
      base = (which[i] == 0) ? rx_s.len() : rx_u.len();
      exp  = exps[i];
      send(which[i], vals[i], t);
      wait_stream(which[i], base, exp.len(), 1'b0, got);
      checks++;
      if (got != exp) begin
        errors++;
        $display("FAIL boundary_%h_dut%0d got=%s want=%s", vals[i], which[i], hexs(got), hexs(exp));
      end
    end
  endtask

  task automatic test_backpressure();
    string got;
    int    t, base, n;
    bit    bad;
    @(posedge clk); #1 out1_ack = 1'b0;
    base = rx_s.len();
    send(0, 16'hFFF9, t);
    n = 0;
    while (out1_stb !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out1_stb !== 1'b1 || out1 !== 8'h2D) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_under_bp got stb=%b out1=%h want 1 2d", out1_stb, out1);
    end
    @(posedge clk); #1 out1_ack = 1'b1;
    wait_stream(0, base, 3, 1'b0, got);
    checks++;
    if (got != "-7\n") begin
      errors++;
      $display("FAIL bytes_neg7 got=%s want=%s", hexs(got), hexs("-7\n"));
    end
  endtask

  task automatic test_reset_mid();
    string got;
    int    t, base, n;
    // mode 0: reset while dividing; mode 1: reset while a byte is held under backpressure
    for (int mode = 0; mode < 2; mode++) begin
      @(posedge clk); #1 out1_ack = (mode == 0);
      send(0, 16'd9999, t);
      n = 0;
      if (mode == 0) repeat (20) @(negedge clk);
      else while (out1_stb !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      checks++;
      if (out1_stb !== 1'b0 || in1_ack !== 1'b0 || out1 !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid_mode%0d got stb=%b ack=%b out1=%h want 0 0 00", mode, out1_stb, in1_ack, out1);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out1_ack = 1'b1;
      base = rx_s.len();
      repeat (120) @(negedge clk);
      checks++;
      if (rx_s.len() != base) begin
        errors++;
        $display("FAIL reset_mid_stale_mode%0d got %0d bytes want 0", mode, rx_s.len() - base);
      end
    end
    base = rx_s.len();
    send(0, 16'd42, t);
    wait_stream(0, base, 3, 1'b0, got);
    checks++;
    if (got != "42\n") begin
      errors++;
      $display("FAIL after_reset_42 got=%s want=%s", hexs(got), hexs("42\n"));
    end
  endtask

  task automatic test_random();
    string got, exp;
    int    t, base;
    logic signed [15:0] sv;
    for (int i = 0; i < 200; i++) begin
      sv   = 16'($urandom);
      exp  = $sformatf("%0d\n", sv);
      base = rx_s.len();
      send(0, sv, t);
      wait_stream(0, base, exp.len(), 1'b1, got);
      checks++;
      if (got != exp) begin
        errors++;
        $display("FAIL random_%0d value=%h got=%s want=%s", i, sv, hexs(got), hexs(exp));
      end
    end
    @(posedge clk); #1 out1_ack = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_latency();
    test_min_neg();
    test_backpressure();
    test_reset_mid();
    test_random();
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
